wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback-side architectural state: 2**GPR_AW x XLEN GPR file plus the
// machine-mode CSR subset, with same-cycle write-through to decode reads.
module wb_regfile #(
    parameter int XLEN   = 64,
    parameter int GPR_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic [GPR_AW-1:0] wb_rd_idx_i,
    input  logic [CSR_AW-1:0] wb_csr_addr_i,
    input  logic [XLEN-1:0]   wb_csr_data_i,
    input  logic              wb_csr_valid_i,
    input  logic [GPR_AW-1:0] rs1_idx_i,
    input  logic [GPR_AW-1:0] rs2_idx_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    input  logic [CSR_AW-1:0] csr_raddr_i,
    output logic [XLEN-1:0]   csr_rdata_o,
    output logic              csr_rhit_o
);

    localparam int NREG = 2 ** GPR_AW;
    localparam int NCSR = 7;

    localparam int S_MSTATUS  = 0;
    localparam int S_MIE      = 1;
    localparam int S_MTVEC    = 2;
    localparam int S_MSCRATCH = 3;
    localparam int S_MEPC     = 4;
    localparam int S_MCAUSE   = 5;
    localparam int S_MTVAL    = 6;

    localparam logic [CSR_AW-1:0] A_MSTATUS  = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] A_MIE      = CSR_AW'(12'h304);
    localparam logic [CSR_AW-1:0] A_MTVEC    = CSR_AW'(12'h305);
    localparam logic [CSR_AW-1:0] A_MSCRATCH = CSR_AW'(12'h340);
    localparam logic [CSR_AW-1:0] A_MEPC     = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] A_MCAUSE   = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] A_MTVAL    = CSR_AW'(12'h343);

    localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(64'h88);
    localparam logic [XLEN-1:0] MSTATUS_MPP   = XLEN'(64'h1800);
    localparam logic [XLEN-1:0] MTVEC_MASK    = ~XLEN'(64'h2);
    localparam logic [XLEN-1:0] MEPC_MASK     = ~XLEN'(64'h3);

    logic [XLEN-1:0] gpr [NREG];
    logic [XLEN-1:0] csr_q [NCSR];

    logic [NCSR-1:0] wsel;
    logic [NCSR-1:0] rsel;
    logic [XLEN-1:0] wlegal;
    logic            csr_byp;

    function automatic logic [NCSR-1:0] csr_dec(input logic [CSR_AW-1:0] a);
        logic [NCSR-1:0] s;
        s = '0;
        unique case (1'b1)
            (a == A_MSTATUS):  s[S_MSTATUS]  = 1'b1;
            (a == A_MIE):      s[S_MIE]      = 1'b1;
            (a == A_MTVEC):    s[S_MTVEC]    = 1'b1;
            (a == A_MSCRATCH): s[S_MSCRATCH] = 1'b1;
            (a == A_MEPC):     s[S_MEPC]     = 1'b1;
            (a == A_MCAUSE):   s[S_MCAUSE]   = 1'b1;
            (a == A_MTVAL):    s[S_MTVAL]    = 1'b1;
            default:           s = '0;
        endcase
        return s;
    endfunction

    // Value a write would read back as; MPP is hardwired to machine mode.
    function automatic logic [XLEN-1:0] csr_legal(
        input logic [NCSR-1:0] s,
        input logic [XLEN-1:0] d
    );
        logic [XLEN-1:0] r;
        r = d;
        unique case (1'b1)
            s[S_MSTATUS]: r = (d & MSTATUS_WMASK) | MSTATUS_MPP;
            s[S_MTVEC]:   r = d & MTVEC_MASK;
            s[S_MEPC]:    r = d & MEPC_MASK;
            default:      r = d;
        endcase
        return r;
    endfunction

    assign wsel   = csr_dec(wb_csr_addr_i);
    assign rsel   = csr_dec(csr_raddr_i);
    assign wlegal = csr_legal(wsel, wb_csr_data_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) gpr[i] <= '0;
        end else if (wb_rd_idx_i != '0) begin
            gpr[wb_rd_idx_i] <= wb_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCSR; k++) csr_q[k] <= '0;
            csr_q[S_MSTATUS] <= MSTATUS_MPP;
        end else if (wb_csr_valid_i) begin
            for (int k = 0; k < NCSR; k++) begin
                if (wsel[k]) csr_q[k] <= wlegal;
            end
        end
    end

    always_comb begin
        rs1_data_o = '0;
        if (!rst && rs1_idx_i != '0) begin
            rs1_data_o = (rs1_idx_i == wb_rd_idx_i) ? wb_data_i
                                                    : gpr[rs1_idx_i];
        end
    end

    always_comb begin
        rs2_data_o = '0;
        if (!rst && rs2_idx_i != '0) begin
            rs2_data_o = (rs2_idx_i == wb_rd_idx_i) ? wb_data_i
                                                    : gpr[rs2_idx_i];
        end
    end

    assign csr_byp = wb_csr_valid_i && (wsel != '0) &&
                     (wb_csr_addr_i == csr_raddr_i);

    always_comb begin
        csr_rdata_o = '0;
        if (rst) begin
            csr_rdata_o = rsel[S_MSTATUS] ? MSTATUS_MPP : '0;
        end else if (csr_byp) begin
            csr_rdata_o = wlegal;
        end else begin
            for (int k = 0; k < NCSR; k++) begin
                if (rsel[k]) csr_rdata_o = csr_q[k];
            end
        end
    end

    assign csr_rhit_o = |rsel;

endmodule
